// File: rtl/ltl_range_nfa_engine.sv
// Runtime-configurable range-STE NFA engine for LTL monitoring.
// Optional report counter output rep_count is enabled with `define LTL_NFA_REPORT_CNT_EN.
module ltl_range_nfa_engine #(
  parameter int N_STATES = 16,
  parameter int SYM_W    = 8,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = $clog2(N_STATES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [SYM_W-1:0]    symbols,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_addr,
  input  logic [SYM_W-1:0]    cfg_lo,
  input  logic [SYM_W-1:0]    cfg_hi,
  input  logic [1:0]          cfg_start,
  input  logic                cfg_report,
  input  logic [N_STATES-1:0] cfg_succ,
  input  logic                clr_sticky,
  output logic                cfg_err,
  output logic [N_STATES-1:0] active,
  output logic [N_STATES-1:0] report_vec,
  output logic                report_any,
  output logic                report_sticky,
  output logic [CNT_W-1:0]    sym_count,
  output logic                first_rep_valid,
  output logic [CNT_W-1:0]    first_rep_idx
`ifdef LTL_NFA_REPORT_CNT_EN
  ,
  output logic [CNT_W-1:0]    rep_count
`endif
);

  localparam logic [1:0] START_SOF = 2'd1;
  localparam logic [1:0] START_ALL = 2'd2;

  logic [SYM_W-1:0]    lo_q    [N_STATES];
  logic [SYM_W-1:0]    hi_q    [N_STATES];
  logic [1:0]          start_q [N_STATES];
  logic [N_STATES-1:0] succ_q  [N_STATES];
  logic [N_STATES-1:0] rep_q;

  logic                sof_pending;
  logic                report_any_prev;
  logic [N_STATES-1:0] match;
  logic [N_STATES-1:0] en;
  logic [N_STATES-1:0] next_active;
  logic                next_report_any;
  logic                addr_ok;
  logic                idle;
  logic                cfg_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Index of the symbol that produced the current report; pinned at all-ones once saturated.
  function automatic logic [CNT_W-1:0] producing_idx(input logic [CNT_W-1:0] v);
    return (&v) ? v : v - CNT_W'(1);
  endfunction

  always_comb begin
    match = '0;
    en    = '0;
    for (int i = 0; i < N_STATES; i++) begin
      match[i] = (symbols >= lo_q[i]) && (symbols <= hi_q[i]);
      en[i]    = (start_q[i] == START_ALL) || ((start_q[i] == START_SOF) && sof_pending);
      for (int j = 0; j < N_STATES; j++) begin
        en[i] = en[i] | (active[j] & succ_q[j][i]);
      end
    end
  end

  assign next_active     = match & en;
  assign next_report_any = |(next_active & rep_q);
  assign report_vec      = active & rep_q;
  assign report_any      = |report_vec;

  assign addr_ok = ({1'b0, cfg_addr} < (IDX_W+1)'(N_STATES));
  assign idle    = (active == '0) || sof_pending;
  assign cfg_ok  = cfg_we && !run && idle && addr_ok;

  // Configuration storage: reset leaves every state unmatchable.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
      for (int i = 0; i < N_STATES; i++) begin
        lo_q[i]    <= '1;
        hi_q[i]    <= '0;
        start_q[i] <= 2'd0;
        succ_q[i]  <= '0;
      end
    end else if (cfg_ok) begin
      for (int i = 0; i < N_STATES; i++) begin
        if (cfg_addr == IDX_W'(i)) begin
          lo_q[i]    <= cfg_lo;
          hi_q[i]    <= cfg_hi;
          start_q[i] <= cfg_start;
          succ_q[i]  <= cfg_succ;
          rep_q[i]   <= cfg_report;
        end
      end
    end
  end

  // Run state, report latching and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      active          <= '0;
      sof_pending     <= 1'b1;
      sym_count       <= '0;
      cfg_err         <= 1'b0;
      report_sticky   <= 1'b0;
      first_rep_valid <= 1'b0;
      first_rep_idx   <= '0;
      report_any_prev <= 1'b0;
    end else begin
      cfg_err         <= cfg_we && !cfg_ok;
      report_any_prev <= report_any;
      if (run) begin
        active      <= next_active;
        sof_pending <= 1'b0;
        sym_count   <= sat_inc(sym_count);
      end
      if (report_any) begin
        report_sticky <= 1'b1;
      end else if (clr_sticky) begin
        report_sticky <= 1'b0;
      end
      if (report_any && !report_any_prev && !first_rep_valid) begin
        first_rep_valid <= 1'b1;
        first_rep_idx   <= producing_idx(sym_count);
      end else if (clr_sticky) begin
        first_rep_valid <= 1'b0;
      end
    end
  end

`ifdef LTL_NFA_REPORT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_count <= '0;
    end else if (clr_sticky) begin
      rep_count <= (run && next_report_any) ? CNT_W'(1) : '0;
    end else if (run && next_report_any) begin
      rep_count <= sat_inc(rep_count);
    end
  end
`endif

endmodule

// File: tb/tb_ltl_range_nfa_engine.sv
// Scoreboard bench for ltl_range_nfa_engine: directed steps queue expected snapshots, a monitor compares.
module tb_ltl_range_nfa_engine;

  localparam int N  = 16;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [7:0]    symbols;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [7:0]    cfg_lo;
  logic [7:0]    cfg_hi;
  logic [1:0]    cfg_start;
  logic          cfg_report;
  logic [N-1:0]  cfg_succ;
  logic          clr_sticky;
  logic          cfg_err;
  logic [N-1:0]  active;
  logic [N-1:0]  report_vec;
  logic          report_any;
  logic          report_sticky;
  logic [15:0]   sym_count;
  logic          first_rep_valid;
  logic [15:0]   first_rep_idx;
  logic [15:0]   repc_dut;

  ltl_range_nfa_engine #(.N_STATES(N), .SYM_W(8), .CNT_W(16), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .cfg_start(cfg_start), .cfg_report(cfg_report), .cfg_succ(cfg_succ),
    .clr_sticky(clr_sticky), .cfg_err(cfg_err), .active(active),
    .report_vec(report_vec), .report_any(report_any), .report_sticky(report_sticky),
    .sym_count(sym_count), .first_rep_valid(first_rep_valid), .first_rep_idx(first_rep_idx)
`ifdef LTL_NFA_REPORT_CNT_EN
    , .rep_count(repc_dut)
`endif
  );

`ifndef LTL_NFA_REPORT_CNT_EN
  assign repc_dut = 16'h0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] rvec;
    logic        rany;
    logic        sticky;
    logic        err;
    logic        fv;
    logic [15:0] cnt;
    logic [15:0] fidx;
    logic [15:0] repc;
  } snap_t;

  typedef struct {
    int    cyc;
    string name;
    snap_t v;
  } exp_t;

  exp_t  q[$];
  snap_t e;
  snap_t got;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  assign got = {active, report_vec, report_any, report_sticky, cfg_err,
                first_rep_valid, sym_count, first_rep_idx, repc_dut};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t t;
      t = q.pop_front();
      checks++;
      if (t.cyc != cyc || got !== t.v) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", t.name, cyc, got, t.v);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [7:0] s, input logic clr);
    exp_t t;
    run        = r;
    symbols    = s;
    clr_sticky = clr;
    t.cyc  = cyc + 1;
    t.name = nm;
    t.v    = e;
`ifndef LTL_NFA_REPORT_CNT_EN
    t.v.repc = 16'h0;
`endif
    q.push_back(t);
    @(posedge clk);
    #1;
    run        = 1'b0;
    clr_sticky = 1'b0;
    cfg_we     = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic rst_step(input string nm);
    reset = 1'b1;
    e     = '0;
    step(nm, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic cfg_w(input string nm, input logic [IW-1:0] a, input logic [7:0] lo,
                       input logic [7:0] hi, input logic [1:0] st, input logic rp,
                       input logic [N-1:0] sc, input logic r, input logic [7:0] s);
    cfg_we     = 1'b1;
    cfg_addr   = a;
    cfg_lo     = lo;
    cfg_hi     = hi;
    cfg_start  = st;
    cfg_report = rp;
    cfg_succ   = sc;
    step(nm, r, s, 1'b0);
  endtask

  task automatic cfg_pair();
    cfg_w("cfg_s0", 5'd0, 8'd0, 8'd31, 2'd1, 1'b0, 16'h0003, 1'b0, 8'h00);
    cfg_w("cfg_s1", 5'd1, 8'd32, 8'd63, 2'd0, 1'b1, 16'h0000, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; symbols = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_lo = '0; cfg_hi = '0; cfg_start = '0; cfg_report = 1'b0; cfg_succ = '0;
    clr_sticky = 1'b0; e = '0;
    repeat (2) @(posedge clk);
    #1;

    rst_step("reset_state");
    e.cnt = 16'd1;
    step("unconfigured_sym", 1'b1, 8'h10, 1'b0);

    // two-state chain: state0 loops, state1 reports
    rst_step("reset_chain");
    cfg_pair();
    e.active = 16'h0001; e.cnt = 16'd1;
    step("chain_05", 1'b1, 8'h05, 1'b0);
    e.cnt = 16'd2;
    step("chain_07", 1'b1, 8'h07, 1'b0);
    e.active = 16'h0002; e.rvec = 16'h0002; e.rany = 1'b1; e.cnt = 16'd3; e.repc = 16'd1;
    step("chain_28", 1'b1, 8'h28, 1'b0);
    e.sticky = 1'b1; e.fv = 1'b1; e.fidx = 16'd2;
    step("first_report", 1'b0, 8'h00, 1'b0);
    e.err = 1'b1;
    cfg_w("cfg_while_busy", 5'd0, 8'd0, 8'd255, 2'd2, 1'b1, 16'hffff, 1'b0, 8'h00);
    e.err = 1'b0;
    step("err_one_cycle", 1'b0, 8'h00, 1'b0);

    // start-of-data semantics
    rst_step("reset_sof");
    cfg_pair();
    e.cnt = 16'd1;
    step("non_start_first", 1'b1, 8'h28, 1'b0);
    e.cnt = 16'd2;
    step("sof_passed", 1'b1, 8'h05, 1'b0);
    cfg_w("cfg_s2", 5'd2, 8'd64, 8'd95, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h00);
    e.cnt = 16'd3;
    step("all_input_00", 1'b1, 8'h00, 1'b0);
    e.active = 16'h0004; e.rvec = 16'h0004; e.rany = 1'b1; e.cnt = 16'd4; e.repc = 16'd1;
    step("all_input_50a", 1'b1, 8'h50, 1'b0);
    e.cnt = 16'd5; e.sticky = 1'b1; e.fv = 1'b1; e.fidx = 16'd3; e.repc = 16'd1;
    step("clr_vs_set", 1'b1, 8'h50, 1'b1);
    e.fv = 1'b0; e.repc = 16'd0;
    step("clr_sticky_held", 1'b0, 8'h00, 1'b1);
    step("after_clr", 1'b0, 8'h00, 1'b0);

    // config write during run is rejected
    rst_step("reset_runcfg");
    cfg_w("cfg_s2_b", 5'd2, 8'd64, 8'd95, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h00);
    e.active = 16'h0004; e.rvec = 16'h0004; e.rany = 1'b1; e.cnt = 16'd1; e.repc = 16'd1;
    e.err = 1'b1;
    cfg_w("cfg_during_run", 5'd2, 8'd0, 8'd0, 2'd2, 1'b1, 16'h0000, 1'b1, 8'h50);
    e.err = 1'b0; e.cnt = 16'd2; e.repc = 16'd2; e.sticky = 1'b1; e.fv = 1'b1; e.fidx = 16'd0;
    step("cfg_unchanged", 1'b1, 8'h50, 1'b0);

    // reset beats a simultaneous write; out-of-range address rejected
    cfg_we = 1'b1; cfg_addr = 5'd2; cfg_lo = 8'd64; cfg_hi = 8'd95;
    cfg_start = 2'd2; cfg_report = 1'b1; cfg_succ = '0;
    rst_step("reset_with_cfg");
    e.cnt = 16'd1;
    step("reset_wins", 1'b1, 8'h50, 1'b0);
    e.err = 1'b1;
    cfg_w("cfg_addr_oob", 5'd16, 8'd0, 8'd255, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h00);
    e.err = 1'b0; e.cnt = 16'd2;
    step("oob_ignored", 1'b1, 8'h50, 1'b0);

    // inverted interval never matches
    rst_step("reset_inverted");
    cfg_w("cfg_inverted", 5'd3, 8'h40, 8'h20, 2'd2, 1'b1, 16'h0008, 1'b0, 8'h00);
    e.cnt = 16'd1;
    step("inv_30", 1'b1, 8'h30, 1'b0);
    e.cnt = 16'd2;
    step("inv_40", 1'b1, 8'h40, 1'b0);
    e.cnt = 16'd3;
    step("inv_20", 1'b1, 8'h20, 1'b0);

    // report counting over five reporting symbols
    rst_step("reset_repcnt");
    cfg_w("cfg_s2_c", 5'd2, 8'd64, 8'd95, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h00);
    e.active = 16'h0004; e.rvec = 16'h0004; e.rany = 1'b1; e.cnt = 16'd1; e.repc = 16'd1;
    step("rep_50_1", 1'b1, 8'h50, 1'b0);
    e.cnt = 16'd2; e.repc = 16'd2; e.sticky = 1'b1; e.fv = 1'b1; e.fidx = 16'd0;
    step("rep_50_2", 1'b1, 8'h50, 1'b0);
    e.cnt = 16'd3; e.repc = 16'd3;
    step("rep_50_3", 1'b1, 8'h50, 1'b0);
    e.cnt = 16'd4; e.repc = 16'd4;
    step("rep_50_4", 1'b1, 8'h50, 1'b0);
    e.cnt = 16'd5; e.repc = 16'd5;
    step("rep_50_5", 1'b1, 8'h50, 1'b0);
    rst_step("reset_after_count");

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
